// File: rtl/addsub_seq_ctrl_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer.
package addsub_seq_ctrl_pkg;

  // 2-bit FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 8;

  // Byte index width: clog2(bytes) with a floor of one bit
  function automatic int idx_w(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/addsub_seq_ctrl_slice8.sv
// 8-bit add/subtract slice: conditional inverter on b feeding an 8-bit adder.
module addsub_slice8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       inv,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic       ovf
);

  logic [7:0] bx;
  logic [7:0] lo;
  logic [1:0] hi;

  // Split at bit 7 so the carry into the MSB is visible for signed overflow
  always_comb begin
    bx   = inv ? ~b : b;
    lo   = {1'b0, a[6:0]} + {1'b0, bx[6:0]} + {7'd0, cin};
    hi   = {1'b0, a[7]} + {1'b0, bx[7]} + {1'b0, lo[7]};
    sum  = {hi[0], lo[6:0]};
    cout = hi[1];
    ovf  = hi[1] ^ lo[7];
  end

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Byte-serial A+B / A-B sequencer reusing one 8-bit slice, LSB first.
module addsub_seq_ctrl
  import addsub_seq_ctrl_pkg::*;
#(
  parameter int BYTES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic                 op_sub,
  input  logic [8*BYTES-1:0]   a,
  input  logic [8*BYTES-1:0]   b,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [8*BYTES-1:0]   result,
  output logic                 carry_out,
  output logic                 overflow,
  output logic                 zero
);

  localparam int W  = 8 * BYTES;
  localparam int IW = idx_w(BYTES);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic            cout_q, cout_d, ovf_q, ovf_d;

  logic [7:0]      s_sum;
  logic            s_cout, s_ovf;
  logic            last;
  logic [W+7:0]    res_shift;

  // Operands shift right one byte per RUN cycle, so the slice always sees byte 0
  addsub_slice8 u_slice (
    .a    (a_q[7:0]),
    .b    (b_q[7:0]),
    .inv  (sub_q),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout),
    .ovf  (s_ovf)
  );

  assign last      = (idx_q == IW'(BYTES - 1));
  assign res_shift = {s_sum, res_q};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_valid)  state_d = ST_RUN;
      ST_RUN:  if (last)         state_d = ST_DONE;
      ST_DONE: if (result_ready) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; zero is only meaningful with result_valid
  always_comb begin
    start_ready  = (state_q == ST_IDLE);
    result_valid = (state_q == ST_DONE);
    result       = res_q;
    carry_out    = cout_q;
    overflow     = ovf_q;
    zero         = (state_q == ST_DONE) && (res_q == '0);
  end

  // Datapath next values: latch on accept, step one byte per RUN cycle
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == ST_IDLE && start_valid) begin
      a_d     = a;
      b_d     = b;
      sub_d   = op_sub;
      idx_d   = '0;
      carry_d = op_sub;   // +1 of two's complement on subtract
    end else if (state_q == ST_RUN) begin
      a_d     = a_q >> 8;
      b_d     = b_q >> 8;
      res_d   = res_shift[W+7:8];  // new byte enters at the top, ends LSB-aligned
      carry_d = s_cout;
      idx_d   = idx_q + IW'(1);
      if (last) begin
        cout_d = s_cout;
        ovf_d  = s_ovf;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Bench for addsub_seq_ctrl: BYTES=4 and BYTES=1 instances against an arithmetic model.
module tb_addsub_seq_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // BYTES=4 instance
  logic        sv4 = 0, sr4, sub4 = 0, rv4, rr4 = 0, co4, ov4, z4;
  logic [31:0] a4 = 0, b4 = 0, r4;
  // BYTES=1 instance
  logic        sv1 = 0, sr1, sub1 = 0, rv1, rr1 = 0, co1, ov1, z1;
  logic [7:0]  a1 = 0, b1 = 0, r1;

  addsub_seq_ctrl #(.BYTES(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start_valid(sv4), .start_ready(sr4), .op_sub(sub4),
    .a(a4), .b(b4), .result_valid(rv4), .result_ready(rr4), .result(r4),
    .carry_out(co4), .overflow(ov4), .zero(z4));

  addsub_seq_ctrl #(.BYTES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start_valid(sv1), .start_ready(sr1), .op_sub(sub1),
    .a(a1), .b(b1), .result_valid(rv1), .result_ready(rr1), .result(r1),
    .carry_out(co1), .overflow(ov1), .zero(z1));

  // Reference: whole-word arithmetic, returns {zero, ovf, carry, result[31:0]}
  function automatic logic [34:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic s, input int w);
    logic [63:0] mask, bb, sum, res;
    logic sa, sbb, sr;
    mask = (64'd1 << w) - 64'd1;
    bb   = s ? (~{32'd0, b} & mask) : {32'd0, b};
    sum  = {32'd0, a} + bb + {63'd0, s};
    res  = sum & mask;
    sa   = a[w-1];
    sbb  = bb[w-1];
    sr   = res[w-1];
    return {res == 0, (sa == sbb) && (sr != sa), sum[w], res[31:0]};
  endfunction

  // One op on the 4-byte DUT. lat counts the accept edge as edge 1; -1 on timeout.
  // Inputs are scrambled right after accept to show the op is insulated from them.
  task automatic op4(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                     output int lat, output logic [34:0] obs);
    @(negedge clk);
    sv4 = 1; a4 = ia; b4 = ib; sub4 = is;
    @(posedge clk);
    #1 sv4 = 0; a4 = $urandom; b4 = $urandom; sub4 = 1'($urandom);
    lat = -1;
    for (int k = 2; k <= 40; k++) begin
      @(posedge clk); #1;
      if (rv4) begin lat = k; break; end
    end
    obs = {z4, ov4, co4, r4};
  endtask

  task automatic take4();
    @(negedge clk); rr4 = 1;
    @(posedge clk); #1 rr4 = 0;
  endtask

  task automatic op1(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                     output int lat, output logic [34:0] obs);
    @(negedge clk);
    sv1 = 1; a1 = ia; b1 = ib; sub1 = is;
    @(posedge clk);
    #1 sv1 = 0; a1 = 8'($urandom); b1 = 8'($urandom); sub1 = 1'($urandom);
    lat = -1;
    for (int k = 2; k <= 40; k++) begin
      @(posedge clk); #1;
      if (rv1) begin lat = k; break; end
    end
    obs = {z1, ov1, co1, 24'd0, r1};
    @(negedge clk); rr1 = 1;
    @(posedge clk); #1 rr1 = 0;
  endtask

  task automatic test_reset();
    total++;
    if ({sr4, rv4, r4, co4, ov4, z4} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
      bad++; $display("FAIL reset4 got sr=%b rv=%b r=%h co=%b ov=%b z=%b want 1 0 0 0 0 0",
                      sr4, rv4, r4, co4, ov4, z4);
    end
    total++;
    if ({sr1, rv1, r1, co1, ov1, z1} !== {1'b1, 1'b0, 8'd0, 3'b000}) begin
      bad++; $display("FAIL reset1 got sr=%b rv=%b r=%h co=%b ov=%b z=%b want 1 0 0 0 0 0",
                      sr1, rv1, r1, co1, ov1, z1);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[5] = '{32'h000000FF, 32'h5, 32'h0, 32'h7FFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vb[5] = '{32'h1, 32'h5, 32'h1, 32'h1, 32'h1};
    logic        vs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    // hand-derived {zero, ovf, carry, result}
    logic [34:0] ve[5] = '{{3'b000, 32'h00000100}, {3'b101, 32'h0}, {3'b000, 32'hFFFFFFFF},
                          {3'b010, 32'h80000000}, {3'b101, 32'h0}};
    int lat; logic [34:0] obs;
    for (int i = 0; i < 5; i++) begin
      op4(va[i], vb[i], vs[i], lat, obs);
      total++;
      if (lat !== 5) begin bad++; $display("FAIL dir%0d_latency got %0d want 5", i, lat); end
      total++;
      if (obs !== ve[i]) begin bad++; $display("FAIL dir%0d got %h want %h", i, obs, ve[i]); end
      take4();
    end
  endtask

  task automatic test_random();
    int lat; logic [34:0] obs, exp;
    logic [31:0] ra, rb; logic rs;
    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      if (i % 6 == 0) rb = ra;
      exp = ref_op(ra, rb, rs, 32);
      op4(ra, rb, rs, lat, obs);
      total++;
      if (lat !== 5 || obs !== exp) begin
        bad++; $display("FAIL rand%0d a=%h b=%h sub=%b got lat=%0d %h want lat=5 %h",
                        i, ra, rb, rs, lat, obs, exp);
      end
      take4();
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [34:0] obs, exp;
    exp = ref_op(32'hDEADBEEF, 32'h12345678, 1'b1, 32);
    op4(32'hDEADBEEF, 32'h12345678, 1'b1, lat, obs);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL bp_first got %h want %h", obs, exp); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); sv4 = i[0]; a4 = $urandom; b4 = $urandom; sub4 = 1'($urandom);
      @(posedge clk); #1;
      total++;
      if ({z4, ov4, co4, r4} !== exp || rv4 !== 1'b1 || sr4 !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got rv=%b sr=%b %h want rv=1 sr=0 %h",
                        i, rv4, sr4, {z4, ov4, co4, r4}, exp);
      end
    end
    @(negedge clk); sv4 = 0; rr4 = 1;
    @(posedge clk); #1 rr4 = 0;
    total++;
    if (sr4 !== 1'b1 || rv4 !== 1'b0) begin
      bad++; $display("FAIL bp_release got sr=%b rv=%b want 1 0", sr4, rv4);
    end
    // nothing pulsed during DONE may have been queued
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (rv4 !== 1'b0 || sr4 !== 1'b1) begin
      bad++; $display("FAIL bp_noqueue got rv=%b sr=%b want 0 1", rv4, sr4);
    end
  endtask

  task automatic test_reset_midrun();
    int lat; logic [34:0] obs;
    @(negedge clk); sv4 = 1; a4 = 32'hAAAA5555; b4 = 32'h11111111; sub4 = 0;
    @(posedge clk); #1 sv4 = 0;
    repeat (2) @(posedge clk);   // two bytes processed, idx now 2
    @(negedge clk); reset_n = 0;
    #1;
    total++;
    if ({sr4, rv4, r4, co4, ov4, z4} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
      bad++; $display("FAIL midrun_reset got sr=%b rv=%b r=%h co=%b ov=%b z=%b want 1 0 0 0 0 0",
                      sr4, rv4, r4, co4, ov4, z4);
    end
    @(negedge clk); reset_n = 1;
    op4(32'h12345678, 32'h00000078, 1'b1, lat, obs);
    total++;
    if (lat !== 5 || obs !== {3'b001, 32'h12345600}) begin
      bad++; $display("FAIL midrun_after got lat=%0d %h want lat=5 %h", lat, obs,
                      {3'b001, 32'h12345600});
    end
    take4();
  endtask

  task automatic test_back_to_back();
    int lat; logic [34:0] obs, exp;
    op4(32'h00010000, 32'h0000FFFF, 1'b0, lat, obs);
    // take and request on the same edge: request must wait one more edge
    @(negedge clk); rr4 = 1; sv4 = 1; a4 = 32'h80000000; b4 = 32'h00000001; sub4 = 1;
    @(posedge clk); #1 rr4 = 0;
    total++;
    if (sr4 !== 1'b1 || rv4 !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got sr=%b rv=%b want 1 0", sr4, rv4);
    end
    @(posedge clk); #1 sv4 = 0; a4 = $urandom;
    total++;
    if (sr4 !== 1'b0) begin bad++; $display("FAIL b2b_accept got sr=%b want 0", sr4); end
    exp = ref_op(32'h80000000, 32'h00000001, 1'b1, 32);
    lat = -1;
    for (int k = 2; k <= 40; k++) begin
      @(posedge clk); #1;
      if (rv4) begin lat = k; break; end
    end
    total++;
    if (lat !== 5 || {z4, ov4, co4, r4} !== exp) begin
      bad++; $display("FAIL b2b_second got lat=%0d %h want lat=5 %h", lat, {z4, ov4, co4, r4}, exp);
    end
    take4();
  endtask

  task automatic test_bytes1();
    int lat; logic [34:0] obs, exp;
    logic [7:0] ra, rb; logic rs;
    op1(8'h80, 8'h80, 1'b0, lat, obs);
    total++;
    if (lat !== 2 || obs !== {3'b111, 32'h0}) begin
      bad++; $display("FAIL b1_dir got lat=%0d %h want lat=2 %h", lat, obs, {3'b111, 32'h0});
    end
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      exp = ref_op({24'd0, ra}, {24'd0, rb}, rs, 8);
      op1(ra, rb, rs, lat, obs);
      total++;
      if (lat !== 2 || obs !== exp) begin
        bad++; $display("FAIL b1_rand%0d a=%h b=%h sub=%b got lat=%0d %h want lat=2 %h",
                        i, ra, rb, rs, lat, obs, exp);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    #20 reset_n = 1;
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    test_bytes1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
